// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine; big-endian byte/half/word to aligned word accesses, sub-word stores as RMW.
// Latency (MIN_WAIT=2, memStall low, accept = cycle 0): rsp_valid in cycle 4 (load), 5 (word store), 7 (sub-word store).
// Backpressure: req_ready only in IDLE; memStall stretches each phase; STALL_TIMEOUT cycles in one phase aborts with rsp_err.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake; req_write, req_size, req_signed, req_addr, req_wdata latched on accept
//   rsp_valid/rsp_rdata/rsp_err   one-cycle completion pulse with load data (0 for stores) and error flag
//   memAdd/memInData/memWrite/memRead/memOutData/memStall   word-wide memory port
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned half/word accesses with rsp_err.
module mem_access_unit #(
  parameter int MIN_WAIT      = 2,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] memAdd,
  output logic [31:0] memInData,
  output logic        memWrite,
  output logic        memRead,
  input  logic [31:0] memOutData,
  input  logic        memStall
);

  typedef enum logic [2:0] {IDLE, RD, RD_DONE, WR_SETUP, WR, WR_HOLD, RESP} state_t;

  localparam logic [15:0] MinEnd     = 16'(MIN_WAIT - 1);
  localparam logic [15:0] TimeoutEnd = 16'(STALL_TIMEOUT - 1);

  state_t      state, nextState;
  logic [15:0] cnt;
  logic        isWrite, isSigned, errReg;
  logic [1:0]  sizeReg;
  logic [31:0] addrReg, wordReg, rdataReg;
  logic        inPhase, phaseEnd, phaseAbort;
  logic        driveAddr, driveData;

  // Pick the addressed lane of a big-endian word and extend it.
  function automatic logic [31:0] loadExtract(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Overlay right-justified store data onto the addressed lane of the old word.
  function automatic logic [31:0] storeMerge(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: begin
        case (off)
          2'd0:    r[31:24] = d[7:0];
          2'd1:    r[23:16] = d[7:0];
          2'd2:    r[15:8]  = d[7:0];
          default: r[7:0]   = d[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0] = d[15:0];
        else        r[31:16] = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  assign inPhase    = (state == RD) || (state == WR);
  assign phaseEnd   = inPhase && (cnt >= MinEnd) && !memStall;
  assign phaseAbort = inPhase && memStall && (cnt >= TimeoutEnd);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
          if (misaligned) nextState = RESP;
          else
`endif
          if (req_write && req_size[1]) nextState = WR_SETUP;
          else                          nextState = RD;
        end
      end
      RD: begin
        if (phaseEnd)        nextState = RD_DONE;
        else if (phaseAbort) nextState = RESP;
      end
      // For an RMW store the merged word is already registered here, so this
      // cycle doubles as the write setup cycle (address/data stable, no strobe).
      RD_DONE:  nextState = isWrite ? WR : RESP;
      WR_SETUP: nextState = WR;
      WR: begin
        if (phaseEnd)        nextState = WR_HOLD;
        else if (phaseAbort) nextState = RESP;
      end
      WR_HOLD:  nextState = RESP;
      RESP:     nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  assign driveAddr = (state == RD) || (state == RD_DONE) || (state == WR_SETUP) ||
                     (state == WR) || (state == WR_HOLD);
  assign driveData = (state == WR_SETUP) || (state == WR) || (state == WR_HOLD) ||
                     ((state == RD_DONE) && isWrite);

  assign req_ready = (state == IDLE);
  assign memRead   = (state == RD);
  assign memWrite  = (state == WR);
  assign memAdd    = driveAddr ? {addrReg[31:2], 2'b00} : 32'h0;
  assign memInData = driveData ? wordReg : 32'h0;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (state == RESP) ? rdataReg : 32'h0;
  assign rsp_err   = (state == RESP) && errReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      isWrite  <= 1'b0;
      isSigned <= 1'b0;
      sizeReg  <= 2'b00;
      addrReg  <= '0;
      wordReg  <= '0;
      rdataReg <= '0;
      errReg   <= 1'b0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && req_valid) begin
        isWrite  <= req_write;
        isSigned <= req_signed;
        sizeReg  <= req_size;
        addrReg  <= req_addr;
        wordReg  <= req_wdata;
        rdataReg <= '0;
        cnt      <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        errReg   <= misaligned;
`else
        errReg   <= 1'b0;
`endif
      end
      if (inPhase) begin
        if (phaseEnd || phaseAbort) cnt <= '0;
        else                        cnt <= cnt + 16'd1;
      end
      if ((state == RD) && phaseEnd) begin
        if (isWrite) wordReg  <= storeMerge(memOutData, wordReg, sizeReg, addrReg[1:0]);
        else         rdataReg <= loadExtract(memOutData, sizeReg, addrReg[1:0], isSigned);
      end
      if (phaseAbort) errReg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized traffic against a word-array reference model.
module tb_mem_access_unit;
  localparam int MinWait      = 2;
  localparam int StallTimeout = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, memAdd, memInData, memOutData;
  logic        memWrite, memRead;
  logic        memStall = 1'b0;

  mem_access_unit #(.MIN_WAIT(MinWait), .STALL_TIMEOUT(StallTimeout)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .memAdd(memAdd), .memInData(memInData), .memWrite(memWrite), .memRead(memRead),
    .memOutData(memOutData), .memStall(memStall)
  );

  always #5 clk = ~clk;

  // Contents of never-written memory words.
  function automatic logic [31:0] initWord(input logic [7:0] idx);
    return {idx, ~idx, idx ^ 8'h5A, 8'hC3};
  endfunction

  // Bench memory: 256 words, combinational read, write on clock when not stalled.
  bit [31:0] memArr [256];
  bit        memWritten [256];
  always @(posedge clk) begin
    if (memWrite && !memStall) begin
      memArr[memAdd[9:2]]     <= memInData;
      memWritten[memAdd[9:2]] <= 1'b1;
    end
  end
  assign memOutData = memWritten[memAdd[9:2]] ? memArr[memAdd[9:2]] : initWord(memAdd[9:2]);

  // Activity monitor.
  int          readCycles = 0, writeCycles = 0, rspCount = 0, stabViol = 0;
  logic        prevW = 1'b0;
  logic [31:0] prevAdd = '0, prevIn = '0;
  always @(posedge clk) begin
    if (memRead)   readCycles  <= readCycles + 1;
    if (memWrite)  writeCycles <= writeCycles + 1;
    if (rsp_valid) rspCount    <= rspCount + 1;
    if (memWrite && prevW && (memAdd !== prevAdd || memInData !== prevIn)) stabViol <= stabViol + 1;
    prevW   <= memWrite;
    prevAdd <= memAdd;
    prevIn  <= memInData;
  end

  bit [31:0] refMem [256];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: byte lanes computed by shift/mask arithmetic on the word array.
  function automatic void modelOp(input logic wr, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] ad, input logic [31:0] wd,
                                  output logic [31:0] expRd, output logic expErr, output int expLat);
    int idx, o, sh, wid;
    logic [31:0] w, mask, v;
    idx = int'(ad[9:2]);
    o   = int'(ad[1:0]);
    w   = refMem[idx];
    wid = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    expErr = 1'b0;
    expRd  = '0;
    expLat = 0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    if ((wid == 16 && ad[0]) || (wid == 32 && o != 0)) begin
      expErr = 1'b1;
      expLat = 1;
      return;
    end
`endif
    if (wid == 8)       sh = (3 - o) * 8;
    else if (wid == 16) sh = ad[1] ? 0 : 16;
    else                sh = 0;
    mask = (wid == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid) - 32'd1);
    if (wr) begin
      refMem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
      expLat = (wid == 32) ? 5 : 7;
    end else begin
      v = (w >> sh) & mask;
      if (sg && wid < 32 && v[wid-1]) v = v | ~mask;
      expRd  = v;
      expLat = 4;
    end
  endfunction

  // mode: 0 no stall, 1 random stall, 2 stall stuck high, 3 stall for cycles 0..10
  task automatic doReq(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd, input int mode,
                       output logic got, output logic [31:0] rd, output logic er, output int lat,
                       output logic readyOk, output logic pulseOk);
    @(negedge clk);
    memStall   = (mode == 2 || mode == 3);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom_range(0, 1));
    req_size   = 2'($urandom_range(0, 3));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    got = 1'b0; rd = 32'hBAD0_BAD0; er = 1'bx; lat = 0; readyOk = 1'b1; pulseOk = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      case (mode)
        1:       memStall = ($urandom_range(0, 3) == 0);
        2:       memStall = 1'b1;
        3:       memStall = (lat <= 10);
        default: memStall = 1'b0;
      endcase
      if (rsp_valid) begin
        got = 1'b1;
        rd  = rsp_rdata;
        er  = rsp_err;
      end else if (req_ready) begin
        readyOk = 1'b0;
      end
    end
    memStall = 1'b0;
    @(negedge clk);
    pulseOk = (rsp_valid === 1'b0) && (req_ready === 1'b1);
  endtask

  task automatic runOp(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd, input int mode,
                       input logic checkLat, output logic [31:0] rd, output logic er, output int lat);
    logic [31:0] expRd;
    logic        expErr, got, readyOk, pulseOk;
    int          expLat, wc0, rc0;
    modelOp(wr, sz, sg, ad, wd, expRd, expErr, expLat);
    wc0 = writeCycles;
    rc0 = readCycles;
    doReq(wr, sz, sg, ad, wd, mode, got, rd, er, lat, readyOk, pulseOk);
    chk("rsp seen", 32'(got), 32'd1);
    chk("rdata", rd, expRd);
    chk("err", 32'(er), 32'(expErr));
    if (checkLat) chk("latency", 32'(lat), 32'(expLat));
    chk("ready low while busy", 32'(readyOk), 32'd1);
    chk("single rsp pulse", 32'(pulseOk), 32'd1);
    chk("addr/data stable under write", 32'(stabViol), 32'd0);
    if (!wr) chk("no write on load", 32'(writeCycles - wc0), 32'd0);
    if (expErr) chk("no read on trap", 32'(readCycles - rc0), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er, got, readyOk, pulseOk, found;
    int          lat, wc0, rc0;

    for (int i = 0; i < 256; i++) refMem[i] = initWord(8'(i));

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset memRead", 32'(memRead), 32'd0);
    chk("reset memWrite", 32'(memWrite), 32'd0);
    chk("reset memAdd", memAdd, 32'h0);
    chk("reset memInData", memInData, 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle req_ready", 32'(req_ready), 32'd1);

    // Word store then word load
    runOp(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, 1'b1, rd, er, lat);
    runOp(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 1'b1, rd, er, lat);
    chk("word load data", rd, 32'hDEADBEEF);

    // Sub-word RMW and extended loads
    runOp(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, 0, 1'b1, rd, er, lat);
    runOp(1'b1, 2'b00, 1'b0, 32'h202, 32'h123456AA, 0, 1'b1, rd, er, lat);
    runOp(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 0, 1'b1, rd, er, lat);
    chk("byte RMW word", rd, 32'h1122AA44);
    runOp(1'b0, 2'b00, 1'b1, 32'h202, 32'h0, 0, 1'b1, rd, er, lat);
    chk("signed byte load", rd, 32'hFFFFFFAA);
    runOp(1'b0, 2'b01, 1'b0, 32'h200, 32'h0, 0, 1'b1, rd, er, lat);
    chk("unsigned half load", rd, 32'h00001122);

    // Stall held for 10 cycles after memRead rises (falls in cycle 11)
    runOp(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3, 1'b0, rd, er, lat);
    chk("stalled load latency", 32'(lat), 32'd13);
    chk("stalled load data", rd, 32'hDEADBEEF);

    // Timeout on sub-word store with memStall stuck high
    wc0 = writeCycles;
    doReq(1'b1, 2'b00, 1'b0, 32'h204, 32'h77, 2, got, rd, er, lat, readyOk, pulseOk);
    chk("timeout rsp seen", 32'(got), 32'd1);
    chk("timeout err", 32'(er), 32'd1);
    chk("timeout rdata", rd, 32'h0);
    chk("timeout latency", 32'(lat), 32'(StallTimeout + 1));
    chk("timeout no write", 32'(writeCycles - wc0), 32'd0);
    chk("timeout ready low", 32'(readyOk), 32'd1);
    runOp(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 0, 1'b1, rd, er, lat);

    // Reset during WR
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h300; req_wdata = 32'h55AA55AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (memWrite) found = 1'b1;
    end
    chk("reset test reached WR", 32'(found), 32'd1);
    wc0 = writeCycles;
    rc0 = rspCount;
    rst_n = 1'b0;
    #1;
    chk("mid-op reset memWrite", 32'(memWrite), 32'd0);
    chk("mid-op reset req_ready", 32'(req_ready), 32'd1);
    chk("mid-op reset rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid-op reset no rsp", 32'(rspCount - rc0), 32'd0);
    chk("mid-op reset no write", 32'(writeCycles - wc0), 32'd0);
    runOp(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 1'b1, rd, er, lat);

    // Misaligned word load
    runOp(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 0, 1'b1, rd, er, lat);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    chk("misaligned trap err", 32'(er), 32'd1);
`else
    chk("misaligned word data", rd, 32'hDEADBEEF);
`endif

    // Randomized traffic over a small window of words to force read-after-write reuse
    for (int i = 0; i < 60; i++) begin
      logic        wr, sg;
      logic [1:0]  sz;
      logic [31:0] ad, wd;
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      ad = 32'h380 + 32'($urandom_range(0, 31));
      wd = $urandom;
      runOp(wr, sz, sg, ad, wd, (i < 30) ? 0 : 1, (i < 30), rd, er, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
